// File: rtl/wb_result_unit.sv
// Write-back stage: turns ALU results, link addresses and data-memory loads
// into register-file writes, and keeps the carry/zero/sign flags.
module wb_result_unit #(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [4:0]  LINK_REG    = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  opcode,
  input  logic [3:0]  fcode,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic [31:0] pc_plus1,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flag_carry,
  output logic        flag_zero,
  output logic        flag_sign,
  output logic        mem_err
);

  typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_ld_rd;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;
  logic        r_carry;
  logic        r_zero;
  logic        r_sign;
  logic        r_mem_err;
  logic        w_accept;

  // Held low during reset so a producer never sees a ready it cannot use.
  assign in_ready = rst_n & (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign flag_carry = r_carry;
  assign flag_zero  = r_zero;
  assign flag_sign  = r_sign;
  assign mem_err    = r_mem_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_ld_rd    <= 5'd0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_sign     <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (opcode)
              3'd0, 3'd1: begin
                r_rf_we    <= (rd != 5'd0);
                r_rf_waddr <= rd;
                r_rf_wdata <= alu_result;
                r_carry    <= alu_carry;
                r_zero     <= (alu_result == 32'd0);
                r_sign     <= alu_result[31];
              end
              3'd2: begin
                if (fcode == 4'd0) begin
                  r_ld_rd <= rd;
                  r_cnt   <= 8'd0;
                  r_state <= S_WAIT_MEM;
                end
              end
              3'd3: begin
                if (fcode == 4'd1) begin
                  r_rf_we    <= (LINK_REG != 5'd0);
                  r_rf_waddr <= LINK_REG;
                  r_rf_wdata <= pc_plus1;
                end
              end
              default: ;
            endcase
          end
        end
        S_WAIT_MEM: begin
          // An ack in the final allowed cycle still completes the load.
          if (mem_ack) begin
            r_rf_we    <= (r_ld_rd != 5'd0);
            r_rf_waddr <= r_ld_rd;
            r_rf_wdata <= mem_rdata;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == TMO_LAST) begin
              r_mem_err <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_result_unit.sv
// Scenario bench for wb_result_unit: expected writes are queued as stimulus
// is driven and matched against every rf_we pulse by a monitor thread.
module tb_wb_result_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [3:0]  fcode;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic [31:0] pc_plus1;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flag_carry;
  logic        flag_zero;
  logic        flag_sign;
  logic        mem_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  wb_result_unit #(.MEM_TIMEOUT(15), .LINK_REG(5'd31)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .fcode(fcode), .rd(rd), .alu_result(alu_result),
    .alu_carry(alu_carry), .pc_plus1(pc_plus1), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_sign(flag_sign),
    .mem_err(mem_err)
  );

  // Waits for ready, presents one transaction for one accept edge, and returns
  // at the falling edge right after the accept.
  task automatic send(input logic [2:0] op, input logic [3:0] fc, input logic [4:0] d,
                      input logic [31:0] res, input logic c, input logic [31:0] pc,
                      input bit exp_wr, input logic [4:0] ea, input logic [31:0] ed);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: in_ready=%b required 1 after %0d cycles", in_ready, t);
    end
    in_valid = 1'b1; opcode = op; fcode = fc; rd = d;
    alu_result = res; alu_carry = c; pc_plus1 = pc;
    if (exp_wr) sb.push_back({ea, ed});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, rf_we, rf_waddr, rf_wdata} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b we=%b waddr=%0d wdata=%h required all 0",
               in_ready, rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++;
    if ({flag_carry, flag_zero, flag_sign, mem_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: c/z/s/err=%b%b%b%b required 0000",
               flag_carry, flag_zero, flag_sign, mem_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_alu();
    send(3'd0, 4'd0, 5'd5, 32'h8000_0000, 1'b1, 32'd0, 1'b1, 5'd5, 32'h8000_0000);
    n_cmp++;
    if ({rf_we, flag_sign, flag_zero, flag_carry} !== 4'b1101) begin
      n_err++;
      $display("FAIL alu_pulse_flags: we/s/z/c=%b%b%b%b required 1101",
               rf_we, flag_sign, flag_zero, flag_carry);
    end
    @(negedge clk);
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h8000_0000}) begin
      n_err++;
      $display("FAIL alu_hold: we=%b waddr=%0d wdata=%h required 0/5/80000000",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_zero_r0();
    send(3'd1, 4'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, flag_zero, flag_sign, flag_carry} !== {1'b0, 5'd0, 32'd0, 3'b100}) begin
      n_err++;
      $display("FAIL r0_suppress: we=%b waddr=%0d wdata=%h z/s/c=%b%b%b required 0/0/0 100",
               rf_we, rf_waddr, rf_wdata, flag_zero, flag_sign, flag_carry);
    end
    send(3'd2, 4'd1, 5'd9, 32'hFFFF_FFFF, 1'b1, 32'h77, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if ({rf_we, rf_waddr, flag_zero, flag_sign, flag_carry} !== {1'b0, 5'd0, 3'b100}) begin
      n_err++;
      $display("FAIL store_noop: we=%b waddr=%0d z/s/c=%b%b%b required 0/0 100",
               rf_we, rf_waddr, flag_zero, flag_sign, flag_carry);
    end
    send(3'd3, 4'd0, 5'd9, 32'h8000_0000, 1'b1, 32'h55, 1'b0, 5'd0, 32'd0);
    send(3'd6, 4'd2, 5'd9, 32'h8000_0000, 1'b1, 32'h55, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if ({rf_we, rf_wdata, flag_zero, flag_sign, flag_carry, in_ready} !== {1'b0, 32'd0, 3'b100, 1'b1}) begin
      n_err++;
      $display("FAIL other_ops_noop: we=%b wdata=%h z/s/c=%b%b%b ready=%b required 0/0 100 1",
               rf_we, rf_wdata, flag_zero, flag_sign, flag_carry, in_ready);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack = 1'b0;
    send(3'd2, 4'd0, 5'd7, 32'h0, 1'b1, 32'h0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL load_busy_%0d: in_ready=%b required 0", i, in_ready);
      end
      if (i < 2) @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    sb.push_back({5'd7, 32'hDEAD_BEEF});
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, in_ready, flag_zero} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL load_write: we=%b waddr=%0d wdata=%h ready=%b z=%b required 1/7/deadbeef/1/1",
               rf_we, rf_waddr, rf_wdata, in_ready, flag_zero);
    end
  endtask

  task automatic test_ack_at_limit();
    send(3'd2, 4'd0, 5'd6, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0);
    repeat (14) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    sb.push_back({5'd6, 32'h1234_5678});
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, mem_err} !== {1'b1, 5'd6, 32'h1234_5678, 1'b0}) begin
      n_err++;
      $display("FAIL ack_at_limit: we=%b waddr=%0d wdata=%h err=%b required 1/6/12345678/0",
               rf_we, rf_waddr, rf_wdata, mem_err);
    end
  endtask

  task automatic test_timeout();
    send(3'd2, 4'd0, 5'd4, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0);
    repeat (14) @(negedge clk);
    n_cmp++;
    if ({mem_err, in_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL timeout_early: err=%b ready=%b required 0/0", mem_err, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_err, in_ready, rf_we} !== 3'b110) begin
      n_err++;
      $display("FAIL timeout_abort: err=%b ready=%b we=%b required 1/1/0", mem_err, in_ready, rf_we);
    end
    send(3'd2, 4'd0, 5'd12, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    sb.push_back({5'd12, 32'hCAFE_0001});
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if ({rf_we, rf_waddr, mem_err} !== {1'b1, 5'd12, 1'b1}) begin
      n_err++;
      $display("FAIL err_sticky: we=%b waddr=%0d err=%b required 1/12/1", rf_we, rf_waddr, mem_err);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; opcode = 3'd3; fcode = 4'd1; rd = 5'd2;
    alu_result = 32'hFFFF_FFFF; alu_carry = 1'b1; pc_plus1 = 32'h40;
    sb.push_back({5'd31, 32'h40});
    @(negedge clk);
    opcode = 3'd0; fcode = 4'd0; rd = 5'd3; alu_result = 32'h11; alu_carry = 1'b0;
    sb.push_back({5'd3, 32'h11});
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'h40}) begin
      n_err++;
      $display("FAIL b2b_link: we=%b waddr=%0d wdata=%h required 1/31/40", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, flag_zero, flag_sign, flag_carry} !== {1'b1, 5'd3, 32'h11, 3'b000}) begin
      n_err++;
      $display("FAIL b2b_alu: we=%b waddr=%0d wdata=%h z/s/c=%b%b%b required 1/3/11 000",
               rf_we, rf_waddr, rf_wdata, flag_zero, flag_sign, flag_carry);
    end
  endtask

  task automatic test_reset_mid_load();
    send(3'd0, 4'd0, 5'd9, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 5'd9, 32'hFFFF_FFFF);
    send(3'd2, 4'd0, 5'd8, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, rf_we, rf_waddr, flag_carry, flag_zero, flag_sign, mem_err} !== 10'd0) begin
      n_err++;
      $display("FAIL midload_reset: ready=%b we=%b waddr=%0d c/z/s/err=%b%b%b%b required all 0",
               in_ready, rf_we, rf_waddr, flag_carry, flag_zero, flag_sign, mem_err);
    end
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if ({rf_we, in_ready, rf_wdata} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL midload_ack_ignored: we=%b ready=%b wdata=%h required 0/1/0",
               rf_we, in_ready, rf_wdata);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; fcode = 4'd0; rd = 5'd0;
    alu_result = 32'd0; alu_carry = 1'b0; pc_plus1 = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;

    fork
      forever begin
        logic [36:0] exp_w;
        @(negedge clk);
        if (rf_we === 1'b1) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_write: waddr=%0d wdata=%h required no write", rf_waddr, rf_wdata);
          end else begin
            exp_w = sb.pop_front();
            if ({rf_waddr, rf_wdata} !== exp_w) begin
              n_err++;
              $display("FAIL sb_write: waddr=%0d wdata=%h required waddr=%0d wdata=%h",
                       rf_waddr, rf_wdata, exp_w[36:32], exp_w[31:0]);
            end
          end
        end
      end
    join_none

    test_reset();
    test_alu();
    test_zero_r0();
    test_load();
    test_ack_at_limit();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d writes outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
